// File: rtl/csm_final_adder_seq.sv
// Sequential final adder for a carry-save multiplier result.
// The upper half of the sum vector is added to the carry vector CHUNK bits per
// cycle, and the carry ripples between chunks through a single carry flop.
// The lower half of the sum vector passes straight through to the product.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a carry-save result; in_ready high
// ADD   | resolving one chunk of the upper half per cycle
// DONE  | product/co valid and held until downstream takes them
module csm_final_adder_seq #(
  parameter int W     = 4,
  parameter int CHUNK = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] s_in,
  input  logic [W-1:0]   carry_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           co
);

  localparam int N     = W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // A partial last chunk would silently drop product bits, so refuse it.
  if ((CHUNK < 1) || (W % CHUNK != 0)) begin : g_bad_chunk
    $error("csm_final_adder_seq: W must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cbit_q, cbit_d;
  logic [W-1:0]     s_hi_q, s_hi_d;
  logic [W-1:0]     carry_q, carry_d;
  logic [2*W-1:0]   product_q, product_d;
  logic             co_q, co_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;

  // Pick the operand chunks addressed by idx and add them with the running carry.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = s_hi_q[i*CHUNK +: CHUNK];
        chunk_b = carry_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, cbit_q};
  end

  // Next-state and datapath update for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cbit_d    = cbit_q;
    s_hi_d    = s_hi_q;
    carry_d   = carry_q;
    product_d = product_q;
    co_d      = co_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          s_hi_d             = s_in[2*W-1:W];
          carry_d            = carry_in;
          product_d[W-1:0]   = s_in[W-1:0];
          cbit_d             = 1'b0;
          idx_d              = '0;
          state_d            = S_ADD;
        end
      end

      S_ADD: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            product_d[W+i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        cbit_d = chunk_sum[CHUNK];
        if (idx_q == IDX_W'(N - 1)) begin
          co_d    = chunk_sum[CHUNK];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        // Result stays frozen here; going back to IDLE costs one cycle before
        // the next accept, which keeps in_ready a pure function of state.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cbit_q    <= 1'b0;
      s_hi_q    <= '0;
      carry_q   <= '0;
      product_q <= '0;
      co_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cbit_q    <= cbit_d;
      s_hi_q    <= s_hi_d;
      carry_q   <= carry_d;
      product_q <= product_d;
      co_q      <= co_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;
  assign co        = co_q;

endmodule
